adc_frame_sequencer: RTL and testbench

Sequences the ADC sample stream into fixed-length frames for the DMA AXI-Stream path under software control. Consumes the control word from the AXI-lite register block and returns the self-clear mask, frame counter, overflow counter and diagnostics word to it. Sits between the ADC receiver and the DMA stream input in zynq_adc_glue.

---
 rtl/adc_frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_adc_frame_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_sequencer.sv
// Frames the ADC sample stream into FRAME_LEN-beat AXI-Stream packets under
// software control (START/STOP/CLR_CNT edges), with counters and diagnostics.
module adc_frame_sequencer #(
    parameter int FRAME_LEN = 1024,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctrl,
    output logic [31:0]       clear_mask,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [31:0]       frame_counter,
    output logic [31:0]       overflow_counter,
    output logic [31:0]       diagnostics
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    // Command bit order in cmd_q/mask_q: [0] START, [1] STOP, [2] CLR_CNT.
    logic [2:0]        cmd_q, cmd_d;
    logic [2:0]        mask_q, mask_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic              cont_q, cont_d;
    logic              stop_q, stop_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [31:0]       fcnt_q, fcnt_d;
    logic [31:0]       ocnt_q, ocnt_d;

    logic start_e, stop_e, clr_e;
    logic hs, done, slot_free, to_finish;
    logic unused_ctrl;

    assign start_e   = ctrl[0] & ~cmd_q[0];
    assign stop_e    = ctrl[1] & ~cmd_q[1];
    assign clr_e     = ctrl[3] & ~cmd_q[2];
    assign hs        = tvalid_q & m_tready;
    assign done      = hs & tlast_q;
    assign slot_free = ~tvalid_q | m_tready;

    always_comb begin
        cmd_d     = {ctrl[3], ctrl[1], ctrl[0]};
        mask_d[0] = start_e | (mask_q[0] & ctrl[0]);
        mask_d[1] = stop_e  | (mask_q[1] & ctrl[1]);
        mask_d[2] = clr_e   | (mask_q[2] & ctrl[3]);
        state_d   = state_q;
        rem_d     = rem_q;
        cont_d    = cont_q;
        stop_d    = stop_q;
        idx_d     = idx_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q & ~m_tready;
        tlast_d   = tlast_q;
        fcnt_d    = done ? fcnt_q + 32'd1 : fcnt_q;
        ocnt_d    = ocnt_q;
        to_finish = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_e && !stop_e) begin
                    rem_d   = (ctrl[15:8] == 8'd0) ? 8'd1 : ctrl[15:8];
                    cont_d  = ctrl[2];
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (done) begin
                    if (!cont_q) rem_d = rem_q - 8'd1;
                    to_finish = stop_q | stop_e | (~cont_q & (rem_q == 8'd1));
                end else if (stop_e) begin
                    // Nothing of the current frame exists yet: stop without a partial frame.
                    if (idx_q == '0 && !tvalid_q) to_finish = 1'b1;
                    else                          stop_d    = 1'b1;
                end
                if (to_finish) begin
                    state_d = ST_FINISH;
                end else if (adc_valid) begin
                    if (slot_free) begin
                        tdata_d  = adc_data;
                        tvalid_d = 1'b1;
                        tlast_d  = (idx_q == LAST_IDX);
                        idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else if (ocnt_q != '1) begin
                        ocnt_d = ocnt_q + 32'd1;
                    end
                end
            end
            ST_FINISH: begin
                if (!tvalid_q) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr_e) begin
            fcnt_d = '0;
            ocnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            mask_q   <= '0;
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            fcnt_q   <= '0;
            ocnt_q   <= '0;
        end else begin
            cmd_q    <= cmd_d;
            mask_q   <= mask_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            fcnt_q   <= fcnt_d;
            ocnt_q   <= ocnt_d;
        end
    end

    assign clear_mask       = {28'd0, mask_q[2], 1'b0, mask_q[1:0]};
    assign m_tdata          = tdata_q;
    assign m_tvalid         = tvalid_q;
    assign m_tlast          = tlast_q;
    assign frame_counter    = fcnt_q;
    assign overflow_counter = ocnt_q;
    assign diagnostics      = {16'(idx_q), rem_q, 5'd0, tvalid_q & ~m_tready, state_q};
    assign unused_ctrl      = ^{ctrl[31:16], ctrl[7:4]};

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Bench for adc_frame_sequencer: directed scenarios plus a long random run,
// all judged against a transaction-level reference model with beat queues.
module tb_adc_frame_sequencer;

    localparam int FL = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   ctrl;
    logic [31:0]   clear_mask;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [31:0]   frame_counter;
    logic [31:0]   overflow_counter;
    logic [31:0]   diagnostics;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_frame_sequencer #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .ctrl            (ctrl),
        .clear_mask      (clear_mask),
        .adc_data        (adc_data),
        .adc_valid       (adc_valid),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .frame_counter   (frame_counter),
        .overflow_counter(overflow_counter),
        .diagnostics     (diagnostics)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        bit          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];

    int          m_state;     // 0 idle, 1 capture, 2 finish
    logic [31:0] m_prev;
    bit          m_ms, m_mp, m_mc;
    int          m_rem;
    bit          m_cont, m_stop;
    int          m_idx;
    bit          m_full, m_last;
    logic [31:0] m_data;
    logic [31:0] m_fcnt, m_ocnt;

    task automatic model_reset();
        m_state = 0; m_prev = '0; m_ms = 0; m_mp = 0; m_mc = 0;
        m_rem = 0; m_cont = 0; m_stop = 0; m_idx = 0;
        m_full = 0; m_last = 0; m_data = '0; m_fcnt = '0; m_ocnt = '0;
    endtask

    task automatic model_step(input logic [31:0] c, input bit v, input logic [31:0] d, input bit r);
        bit s, t, k, hs, fin, took;
        s = c[0] && !m_prev[0];
        t = c[1] && !m_prev[1];
        k = c[3] && !m_prev[3];
        hs = m_full && r;
        fin = 0;
        took = 0;
        if (hs) exp_q.push_back('{m_data, m_last});
        if (hs && m_last) m_fcnt = m_fcnt + 1;
        m_ms = s || (m_ms && c[0]);
        m_mp = t || (m_mp && c[1]);
        m_mc = k || (m_mc && c[3]);
        if (m_state == 0) begin
            if (s && !t) begin
                m_rem = (c[15:8] == 0) ? 1 : int'(c[15:8]);
                m_cont = c[2]; m_idx = 0; m_stop = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (hs && m_last) begin
                if (!m_cont) m_rem = m_rem - 1;
                fin = m_stop || t || (!m_cont && m_rem == 0);
            end else if (t) begin
                if (m_idx == 0 && !m_full) fin = 1;
                else m_stop = 1;
            end
            if (fin) m_state = 2;
            else if (v) begin
                if (!m_full || r) begin
                    took = 1;
                    m_data = d;
                    m_last = (m_idx == FL - 1);
                    m_idx = (m_idx + 1) % FL;
                end else if (m_ocnt != 32'hFFFF_FFFF) begin
                    m_ocnt = m_ocnt + 1;
                end
            end
        end else begin
            if (!m_full) begin m_state = 0; m_stop = 0; end
        end
        m_full = took || (m_full && !r);
        if (k) begin m_fcnt = '0; m_ocnt = '0; end
        m_prev = c;
    endtask

    function automatic int beat_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i])
            if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l) return i;
        return -1;
    endfunction

    // One clock: drive at negedge, record DUT handshake, advance model, land on next negedge.
    task automatic cyc(input logic [31:0] c, input bit v, input logic [31:0] d, input bit r, input bit rst);
        ctrl = c; adc_valid = v; adc_data = d; m_tready = r; reset = rst;
        if (!rst && m_tvalid === 1'b1 && m_tready) got_q.push_back('{m_tdata, m_tlast});
        if (rst) model_reset();
        else model_step(c, v, d, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc('0, 0, '0, 1, 1);
        cyc('0, 0, '0, 1, 1);
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
        checks++; if (frame_counter !== '0) begin failures++; $display("FAIL reset_fcnt got=%h exp=0", frame_counter); end
        checks++; if (overflow_counter !== '0) begin failures++; $display("FAIL reset_ocnt got=%h exp=0", overflow_counter); end
        checks++; if (clear_mask !== '0) begin failures++; $display("FAIL reset_mask got=%h exp=0", clear_mask); end
        checks++; if (diagnostics !== '0) begin failures++; $display("FAIL reset_diag got=%h exp=0", diagnostics); end
    endtask

    task automatic test_frames();
        logic [31:0] c;
        do_reset();
        c = 32'h0000_0201;
        for (int i = 0; i < 14; i++) begin
            cyc(c, 1, $urandom, 1, 0);
            checks++;
            if (clear_mask[0] !== 1'b1) begin failures++; $display("FAIL frames_mask0_held cyc=%0d got=%b exp=1", i, clear_mask[0]); end
        end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL frames_beats got=%0d exp=8", got_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q[i].l !== (i == 3 || i == 7)) begin failures++; $display("FAIL frames_tlast beat=%0d got=%b", i, got_q[i].l); end
        end
        checks++; if (beat_diff() != -1) begin failures++; $display("FAIL frames_data got=%0d exp=%0d beats", got_q.size(), exp_q.size()); end
        checks++; if (frame_counter !== 32'd2) begin failures++; $display("FAIL frames_fcnt got=%0d exp=2", frame_counter); end
        checks++; if (diagnostics[1:0] !== 2'd0) begin failures++; $display("FAIL frames_idle got=%0d exp=0", diagnostics[1:0]); end
        cyc('0, 0, '0, 1, 0);
        checks++; if (clear_mask !== '0) begin failures++; $display("FAIL frames_mask_clear got=%h exp=0", clear_mask); end
    endtask

    task automatic test_stop();
        logic [31:0] c;
        do_reset();
        c = 32'h5;
        cyc(c, 0, '0, 1, 0);
        cyc(c, 1, $urandom, 1, 0);
        cyc(c, 1, $urandom, 1, 0);
        c = 32'h7;
        for (int i = 0; i < 6; i++) cyc(c, 1, $urandom, 1, 0);
        checks++; if (clear_mask !== 32'h3) begin failures++; $display("FAIL stop_mask got=%h exp=3", clear_mask); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL stop_beats got=%0d exp=4", got_q.size()); end
        else begin
            checks++; if (got_q[3].l !== 1'b1) begin failures++; $display("FAIL stop_tlast got=%b exp=1", got_q[3].l); end
        end
        checks++; if (beat_diff() != -1) begin failures++; $display("FAIL stop_data got=%0d exp=%0d beats", got_q.size(), exp_q.size()); end
        checks++; if (frame_counter !== 32'd1) begin failures++; $display("FAIL stop_fcnt got=%0d exp=1", frame_counter); end
        checks++; if (diagnostics[1:0] !== 2'd0) begin failures++; $display("FAIL stop_idle got=%0d exp=0", diagnostics[1:0]); end
        cyc(32'h5, 0, '0, 1, 0);
        checks++; if (clear_mask[1] !== 1'b0) begin failures++; $display("FAIL stop_mask1_clear got=%b exp=0", clear_mask[1]); end
    endtask

    task automatic test_stall();
        logic [31:0] c, d0;
        do_reset();
        c = 32'h5;
        cyc(c, 0, '0, 1, 0);
        cyc(c, 1, $urandom, 1, 0);
        cyc(c, 1, $urandom, 1, 0);
        cyc(c, 0, '0, 1, 0);
        d0 = $urandom;
        cyc(c, 1, d0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(c, 1, $urandom, 0, 0);
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== d0) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", i, m_tvalid, m_tdata, d0); end
        end
        checks++; if (overflow_counter !== 32'd2) begin failures++; $display("FAIL stall_ocnt got=%0d exp=2", overflow_counter); end
        checks++; if (diagnostics[2] !== 1'b1) begin failures++; $display("FAIL stall_diag got=%b exp=1", diagnostics[2]); end
        cyc(c, 0, '0, 1, 0);
        cyc(c, 0, '0, 1, 0);
        checks++; if (beat_diff() != -1) begin failures++; $display("FAIL stall_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL stall_nodup got=%0d exp=3", got_q.size()); end
    endtask

    task automatic test_saturate();
        logic [31:0] c;
        bit hit;
        do_reset();
        c = 32'h5;
        cyc(c, 0, '0, 1, 0);
        force dut.ocnt_q = 32'hFFFF_FFFE;
        #1 release dut.ocnt_q;
        m_ocnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) cyc(c, 1, $urandom, 0, 0);
        checks++; if (overflow_counter !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_ocnt got=%h exp=ffffffff", overflow_counter); end
        hit = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (m_tvalid && m_tlast) begin
                cyc(c | 32'h8, 1, $urandom, 1, 0);
                hit = 1;
            end else cyc(c, 1, $urandom, 1, 0);
        end
        checks++; if (!hit) begin failures++; $display("FAIL sat_no_tlast got=0 exp=1"); end
        checks++; if (frame_counter !== '0 || overflow_counter !== '0) begin failures++; $display("FAIL sat_clear got=%0d/%0d exp=0/0", frame_counter, overflow_counter); end
        checks++; if (clear_mask !== 32'h9) begin failures++; $display("FAIL sat_mask got=%h exp=9", clear_mask); end
    endtask

    task automatic test_start_stop();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(32'h0303, 1, $urandom, 1, 0);
        checks++; if (diagnostics[1:0] !== 2'd0) begin failures++; $display("FAIL ss_state got=%0d exp=0", diagnostics[1:0]); end
        checks++; if (clear_mask !== 32'h3) begin failures++; $display("FAIL ss_mask got=%h exp=3", clear_mask); end
        checks++; if (got_q.size() != 0 || m_tvalid !== 1'b0) begin failures++; $display("FAIL ss_beats got=%0d exp=0", got_q.size()); end
        checks++; if (overflow_counter !== '0) begin failures++; $display("FAIL ss_ocnt got=%0d exp=0", overflow_counter); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        cyc(32'h5, 0, '0, 1, 0);
        cyc(32'h5, 1, $urandom, 1, 0);
        cyc(32'h5, 1, $urandom, 1, 0);
        cyc('0, 1, $urandom, 1, 1);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (frame_counter !== '0 || overflow_counter !== '0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", frame_counter, overflow_counter); end
        checks++; if (diagnostics !== '0) begin failures++; $display("FAIL rmid_diag got=%h exp=0", diagnostics); end
        exp_q.delete();
        got_q.delete();
        cyc(32'h5, 0, '0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(32'h5, 1, $urandom, 1, 0);
        cyc(32'h5, 0, '0, 1, 0);
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL rmid_beats got=%0d exp=4", got_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (got_q[i].l !== (i == 3)) begin failures++; $display("FAIL rmid_tlast beat=%0d got=%b", i, got_q[i].l); end
        end
        checks++; if (beat_diff() != -1) begin failures++; $display("FAIL rmid_data got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] rc, ed;
        bit rst;
        do_reset();
        rc = '0;
        for (int n = 0; n < 3000 && failures < 20; n++) begin
            if ($urandom_range(0, 7) == 0)  rc[0] = ~rc[0];
            if ($urandom_range(0, 29) == 0) rc[1] = ~rc[1];
            if ($urandom_range(0, 49) == 0) rc[3] = ~rc[3];
            if (!rc[0]) begin rc[2] = 1'($urandom_range(0, 1)); rc[15:8] = 8'($urandom_range(0, 3)); end
            rc[7:4] = 4'($urandom);
            rc[31:16] = 16'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            cyc(rc, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, rst);
            checks++; if (m_tvalid !== m_full) begin failures++; $display("FAIL rnd_tvalid n=%0d got=%b exp=%b", n, m_tvalid, m_full); end
            if (m_full) begin
                checks++; if (m_tdata !== m_data || m_tlast !== m_last) begin failures++; $display("FAIL rnd_beat n=%0d got=%h/%b exp=%h/%b", n, m_tdata, m_tlast, m_data, m_last); end
            end
            checks++; if (frame_counter !== m_fcnt) begin failures++; $display("FAIL rnd_fcnt n=%0d got=%0d exp=%0d", n, frame_counter, m_fcnt); end
            checks++; if (overflow_counter !== m_ocnt) begin failures++; $display("FAIL rnd_ocnt n=%0d got=%0d exp=%0d", n, overflow_counter, m_ocnt); end
            checks++; if (clear_mask !== {28'd0, m_mc, 1'b0, m_mp, m_ms}) begin failures++; $display("FAIL rnd_mask n=%0d got=%h", n, clear_mask); end
            ed = {16'(m_idx), 8'(m_rem), 5'd0, m_full && !m_tready, 2'(m_state)};
            checks++; if (diagnostics !== ed) begin failures++; $display("FAIL rnd_diag n=%0d got=%h exp=%h", n, diagnostics, ed); end
        end
        checks++; if (beat_diff() != -1) begin failures++; $display("FAIL rnd_stream got=%0d exp=%0d beats", got_q.size(), exp_q.size()); end
    endtask

    initial begin
        ctrl = '0; adc_valid = 0; adc_data = '0; m_tready = 1; reset = 1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_frames();
        test_stop();
        test_stall();
        test_saturate();
        test_start_stop();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
